// File: rtl/pipelined_adder.sv
// Segmented, pipelined adder/subtractor: one SEG-bit ripple segment per stage, valid/ready on both sides.
// Optional signed-overflow output is built when PIPELINED_ADDER_OVF_EN is defined; otherwise ovf is tied to 0.
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  if (WIDTH % SEG != 0) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a multiple of SEG");
  end

  function automatic logic [SEG:0] ripple_add(input logic [SEG-1:0] x,
                                              input logic [SEG-1:0] y,
                                              input logic           ci);
    logic           c;
    logic [SEG-1:0] s;
    c = ci;
    s = {SEG{1'b0}};
    for (int i = 0; i < SEG; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

`ifdef PIPELINED_ADDER_OVF_EN
  function automatic logic carry_into_msb(input logic [SEG-1:0] x,
                                          input logic [SEG-1:0] y,
                                          input logic           ci);
    logic c;
    c = ci;
    for (int i = 0; i < SEG - 1; i++) begin
      c = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return c;
  endfunction
`endif

  logic [WIDTH-1:0]  w_b_eff;
  logic [STAGES-1:0] w_v;
  logic [STAGES-1:0] w_ready;

  assign w_b_eff  = sub ? ~b : b;
  assign in_ready = w_ready[0];

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    localparam int HI  = (k + 1) * SEG;
    localparam int REM = WIDTH - HI;

    logic           w_src_v;
    logic           w_src_c;
    logic [SEG-1:0] w_src_a;
    logic [SEG-1:0] w_src_b;
    logic [SEG:0]   w_seg;
    logic [HI-1:0]  w_next_s;
    logic           r_v;
    logic           r_c;
    logic [HI-1:0]  r_s;

    if (k == 0) begin : g_head
      assign w_src_v  = in_valid;
      assign w_src_a  = a[SEG-1:0];
      assign w_src_b  = w_b_eff[SEG-1:0];
      assign w_src_c  = sub | cin;
      assign w_next_s = w_seg[SEG-1:0];
    end else begin : g_body
      assign w_src_v  = w_v[k-1];
      assign w_src_a  = g_stage[k-1].g_buf.r_a[SEG-1:0];
      assign w_src_b  = g_stage[k-1].g_buf.r_b[SEG-1:0];
      assign w_src_c  = g_stage[k-1].r_c;
      assign w_next_s = {w_seg[SEG-1:0], g_stage[k-1].r_s};
    end

    assign w_seg = ripple_add(w_src_a, w_src_b, w_src_c);
    assign w_v[k] = r_v;
    // A stage may load unless it and every stage after it are full while the output stalls.
    assign w_ready[k] = out_ready | ~(&w_v[STAGES-1:k]);

    // Stage valid bit, resolved low sum bits and segment carry.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= {HI{1'b0}};
      end else if (w_ready[k]) begin
        r_v <= w_src_v;
        if (w_src_v) begin
          r_c <= w_seg[SEG];
          r_s <= w_next_s;
        end
      end
    end

    if (k < STAGES - 1) begin : g_buf
      logic [REM-1:0] r_a;
      logic [REM-1:0] r_b;
      logic [REM-1:0] w_next_a;
      logic [REM-1:0] w_next_b;

      if (k == 0) begin : g_cap
        assign w_next_a = a[WIDTH-1:SEG];
        assign w_next_b = w_b_eff[WIDTH-1:SEG];
      end else begin : g_shift
        assign w_next_a = g_stage[k-1].g_buf.r_a[REM+SEG-1:SEG];
        assign w_next_b = g_stage[k-1].g_buf.r_b[REM+SEG-1:SEG];
      end

      // Skew buffer carrying the not-yet-added operand bits down the pipe.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= {REM{1'b0}};
          r_b <= {REM{1'b0}};
        end else if (w_ready[k] && w_src_v) begin
          r_a <= w_next_a;
          r_b <= w_next_b;
        end
      end
    end

    if (k == STAGES - 1) begin : g_tail
      assign out_valid = r_v;
      assign sum       = r_s;
      assign cout      = r_c;
`ifdef PIPELINED_ADDER_OVF_EN
      logic r_cmsb;

      // Carry into the MSB, loaded alongside the final segment so it holds through stalls.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cmsb <= 1'b0;
        end else if (w_ready[k] && w_src_v) begin
          r_cmsb <= carry_into_msb(w_src_a, w_src_b, w_src_c);
        end
      end

      assign ovf = r_cmsb ^ r_c;
`else
      assign ovf = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder: 32/8 instance plus a single-stage 8/8 instance.
module tb_pipelined_adder;

`ifdef PIPELINED_ADDER_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;
  logic        d_in_valid, d_in_ready, d_out_valid, d_cout, d_ovf;
  logic [7:0]  d_a, d_b, d_sum;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_adder #(.WIDTH(8), .SEG(8)) dut_deg (
    .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .a(d_a), .b(d_b), .cin(1'b0), .sub(1'b0), .out_valid(d_out_valid),
    .out_ready(1'b1), .sum(d_sum), .cout(d_cout), .ovf(d_ovf)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one beat and wait the four-stage latency, checking it is neither early nor late.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic ic, input logic is);
    a = ia; b = ib; cin = ic; sub = is; in_valid = 1'b1;
    #1 chk1("op_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk1("op_not_early", out_valid, 1'b0);
    tick();
    chk1("op_out_valid", out_valid, 1'b1);
  endtask

  initial begin
    int nb, nr, st, seen;
    rst_n = 1'b0; in_valid = 1'b0; a = 32'h0; b = 32'h0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1; d_in_valid = 1'b0; d_a = 8'h0; d_b = 8'h0;
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk32("rst_sum", sum, 32'h0);
    chk1("rst_cout", cout, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    #1 chk1("rst_in_ready", in_ready, 1'b1);

    run_op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
    chk32("carry_sum", sum, 32'h0000_0000);
    chk1("carry_cout", cout, 1'b1);
    tick();
    chk1("carry_retired", out_valid, 1'b0);

    run_op(32'd5, 32'd7, 1'b1, 1'b1);
    chk32("sub_sum", sum, 32'hFFFF_FFFE);
    chk1("sub_cout", cout, 1'b0);
    chk1("sub_ovf", ovf, 1'b0);
    tick();

    run_op(32'd7, 32'd5, 1'b0, 1'b1);
    chk32("sub2_sum", sum, 32'h0000_0002);
    chk1("sub2_cout", cout, 1'b1);
    tick();

    run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    chk32("ovf_sum", sum, 32'h8000_0000);
    chk1("ovf_cout", cout, 1'b0);
    chk1("ovf_flag", ovf, OVF_ON);
    tick();

    run_op(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0);
    chk32("seg_sum", sum, 32'h0100_0100);
    chk1("seg_cout", cout, 1'b0);
    tick();

    d_a = 8'h80; d_b = 8'h80; d_in_valid = 1'b1;
    #1 chk1("deg_not_early", d_out_valid, 1'b0);
    chk1("deg_in_ready", d_in_ready, 1'b1);
    tick();
    d_in_valid = 1'b0;
    chk1("deg_out_valid", d_out_valid, 1'b1);
    chk8("deg_sum", d_sum, 8'h00);
    chk1("deg_cout", d_cout, 1'b1);
    chk1("deg_ovf", d_ovf, OVF_ON);
    tick();
    chk1("deg_retired", d_out_valid, 1'b0);

    // Unstalled stream: results 0,2,..,14 on consecutive cycles after a 4-cycle fill.
    sub = 1'b0; cin = 1'b0;
    for (int c = 0; c < 13; c++) begin
      in_valid = (c < 8); a = c; b = c;
      tick();
      chk1("tp_valid", out_valid, (c >= 3 && c <= 10));
      if (c >= 3 && c <= 10) chk32("tp_sum", sum, 32'(2 * (c - 3)));
    end
    in_valid = 1'b0;

    // Stream with a 3-cycle output stall while result 3 is presented.
    nb = 0; nr = 0; st = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid && nr == 3 && st < 3) begin
        out_ready = 1'b0;
        st++;
      end else begin
        out_ready = 1'b1;
      end
      in_valid = (nb < 8); a = nb; b = nb;
      #1;
      if (!out_ready) begin
        chk32("bp_hold_sum", sum, 32'd6);
        chk1("bp_in_ready_low", in_ready, 1'b0);
      end
      if (out_valid && out_ready) begin
        chk32("bp_sum", sum, 32'(2 * nr));
        nr++;
      end
      if (in_valid && in_ready) nb++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk32("bp_results", 32'(nr), 32'd8);
    chk32("bp_accepted", 32'(nb), 32'd8);
    chk32("bp_stall_cycles", 32'(st), 32'd3);
    chk1("bp_drained", out_valid, 1'b0);

    // Reset with three beats in flight: none of them may emerge.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'd100 + 32'(i); b = 32'd1;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1 chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk32("mid_rst_sum", sum, 32'h0);
    tick();
    rst_n = 1'b1;
    #1 chk1("mid_rst_in_ready", in_ready, 1'b1);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid) seen++;
    end
    chk32("mid_rst_no_ghost", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
